// File: rtl/prog_mem_loader.sv
// prog_mem_loader: writer side of the PicoBlaze program-memory port.
// Assembles framed bytes (SYNC, LEN_HI, LEN_LO, N x 3-byte words) into
// 18-bit instructions, writes them to program memory and holds the CPU
// in reset until the image is complete.
// Optional feature macro: LOADER_CHECKSUM_EN (trailing mod-256 checksum byte).
module prog_mem_loader #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter logic [9:0]  BASE_ADDR      = 10'd0,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd5000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        mem_port_wr,
  output logic [9:0]  mem_port_addr,
  output logic [17:0] mem_port_data,
  output logic        cpu_rst,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LEN_HI = 3'd1;
  localparam logic [2:0] ST_LEN_LO = 3'd2;
  localparam logic [2:0] ST_W0     = 3'd3;
  localparam logic [2:0] ST_W1     = 3'd4;
  localparam logic [2:0] ST_W2     = 3'd5;
`ifdef LOADER_CHECKSUM_EN
  localparam logic [2:0] ST_CSUM   = 3'd6;
`endif
  localparam logic [2:0] ST_ERR    = 3'd7;

  logic [2:0]  state;
  logic [1:0]  b0_hi;
  logic [7:0]  b1;
  logic [9:0]  len;       // word count minus one
  logic [9:0]  word_idx;
  logic [23:0] tmo_cnt;
  logic        active;
  logic        tmo_hit;
  logic        is_sync;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  csum;
`else
  logic        finish_pend;
`endif

  assign active  = (state != ST_IDLE) && (state != ST_ERR);
  assign is_sync = rx_valid && (rx_data == SYNC_BYTE);
  // The idle counter sits one below the limit on the last allowed quiet cycle.
  assign tmo_hit = active && !rx_valid && (tmo_cnt == TIMEOUT_CYCLES - 24'd1);

  // Idle-gap counter: cleared by any byte or outside a frame, counts otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= 24'd0;
    end else if (rx_valid || !active) begin
      tmo_cnt <= 24'd0;
    end else begin
      tmo_cnt <= tmo_cnt + 24'd1;
    end
  end

  // Frame parser, word assembly, memory write strobe and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      b0_hi         <= 2'd0;
      b1            <= 8'd0;
      len           <= 10'd0;
      word_idx      <= 10'd0;
      mem_port_wr   <= 1'b0;
      mem_port_addr <= 10'd0;
      mem_port_data <= 18'd0;
      cpu_rst       <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum          <= 8'd0;
`else
      finish_pend   <= 1'b0;
`endif
    end else begin
      mem_port_wr <= 1'b0;
      done        <= 1'b0;
`ifndef LOADER_CHECKSUM_EN
      // Finish lands one cycle after the final write strobe.
      finish_pend <= 1'b0;
      if (finish_pend) begin
        done    <= 1'b1;
        busy    <= 1'b0;
        cpu_rst <= 1'b0;
      end
`endif
`ifdef LOADER_CHECKSUM_EN
      if (rx_valid && (state == ST_LEN_HI || state == ST_LEN_LO ||
                       state == ST_W0 || state == ST_W1 || state == ST_W2)) begin
        csum <= csum + rx_data;
      end
`endif
      if (tmo_hit) begin
        state <= ST_ERR;
        err   <= 1'b1;
        busy  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE, ST_ERR: begin
            if (is_sync) begin
              state    <= ST_LEN_HI;
              busy     <= 1'b1;
              cpu_rst  <= 1'b1;
              err      <= 1'b0;
              word_idx <= 10'd0;
`ifdef LOADER_CHECKSUM_EN
              csum     <= 8'd0;
`endif
            end
          end
          ST_LEN_HI: begin
            if (rx_valid) begin
              if (rx_data[7:2] != 6'd0) begin
                state <= ST_ERR;
                err   <= 1'b1;
                busy  <= 1'b0;
              end else begin
                len[9:8] <= rx_data[1:0];
                state    <= ST_LEN_LO;
              end
            end
          end
          ST_LEN_LO: begin
            if (rx_valid) begin
              len[7:0] <= rx_data;
              state    <= ST_W0;
            end
          end
          ST_W0: begin
            if (rx_valid) begin
              if (rx_data[7:2] != 6'd0) begin
                state <= ST_ERR;
                err   <= 1'b1;
                busy  <= 1'b0;
              end else begin
                b0_hi <= rx_data[1:0];
                state <= ST_W1;
              end
            end
          end
          ST_W1: begin
            if (rx_valid) begin
              b1    <= rx_data;
              state <= ST_W2;
            end
          end
          ST_W2: begin
            if (rx_valid) begin
              mem_port_wr   <= 1'b1;
              mem_port_data <= {b0_hi, b1, rx_data};
              mem_port_addr <= BASE_ADDR + word_idx;
              word_idx      <= word_idx + 10'd1;
              if (word_idx == len) begin
`ifdef LOADER_CHECKSUM_EN
                state       <= ST_CSUM;
`else
                state       <= ST_IDLE;
                finish_pend <= 1'b1;
`endif
              end else begin
                state <= ST_W0;
              end
            end
          end
`ifdef LOADER_CHECKSUM_EN
          ST_CSUM: begin
            if (rx_valid) begin
              busy <= 1'b0;
              if (rx_data == csum) begin
                state   <= ST_IDLE;
                done    <= 1'b1;
                cpu_rst <= 1'b0;
              end else begin
                state <= ST_ERR;
                err   <= 1'b1;
              end
            end
          end
`endif
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_mem_loader.sv
// Directed testbench for prog_mem_loader (short timeout of 100 cycles).
// Build with LOADER_CHECKSUM_EN defined to exercise the checksum byte.
module tb_prog_mem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        mem_port_wr;
  logic [9:0]  mem_port_addr;
  logic [17:0] mem_port_data;
  logic        cpu_rst;
  logic        busy;
  logic        done;
  logic        err;

  int          total = 0;
  int          bad = 0;
  logic [7:0]  tb_sum = 8'd0;
  int          wr_cnt = 0;
  int          done_cnt = 0;
  logic [9:0]  wr_addr [0:2047];
  logic [17:0] wr_data [0:2047];

  prog_mem_loader #(
    .SYNC_BYTE(8'hA5),
    .BASE_ADDR(10'd0),
    .TIMEOUT_CYCLES(24'd100)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .mem_port_wr(mem_port_wr),
    .mem_port_addr(mem_port_addr),
    .mem_port_data(mem_port_data),
    .cpu_rst(cpu_rst),
    .busy(busy),
    .done(done),
    .err(err)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  // Log every memory write and done pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_port_wr === 1'b1) begin
      if (wr_cnt < 2048) begin
        wr_addr[wr_cnt] = mem_port_addr;
        wr_data[wr_cnt] = mem_port_data;
      end
      wr_cnt = wr_cnt + 1;
    end
    if (done === 1'b1) done_cnt = done_cnt + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total = total + 1;
    assert (observed === expected) else begin
      bad = bad + 1;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    tb_sum   = tb_sum + b;
  endtask

  task automatic sendSync();
    applyStimulus(8'hA5);
    tb_sum = 8'd0;
  endtask

  task automatic sendCsum(input logic [7:0] delta);
`ifdef LOADER_CHECKSUM_EN
    applyStimulus(tb_sum + delta);
`else
    if (delta != 8'd0) idleCycles(0);
`endif
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic waitDone();
    logic got;
    got = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (!got) begin
        if (done === 1'b1) got = 1'b1;
        else begin
          @(posedge clk);
          #1;
        end
      end
    end
    checkOutput("done_seen", {31'd0, got}, 32'd1);
  endtask

  initial begin
    int base;
    int dbase;
    logic [17:0] w;

    rst = 1'b1;
    rx_valid = 1'b0;
    rx_data = 8'd0;
    idleCycles(2);
    checkOutput("rst_wr", {31'd0, mem_port_wr}, 32'd0);
    checkOutput("rst_addr", {22'd0, mem_port_addr}, 32'd0);
    checkOutput("rst_data", {14'd0, mem_port_data}, 32'd0);
    checkOutput("rst_cpu_rst", {31'd0, cpu_rst}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_done_err", {30'd0, done, err}, 32'd0);
    rst = 1'b0;
    idleCycles(1);

    // Single word frame.
    base = wr_cnt; dbase = done_cnt;
    sendSync();
    checkOutput("sw_busy", {31'd0, busy}, 32'd1);
    checkOutput("sw_cpu_rst_on", {31'd0, cpu_rst}, 32'd1);
    applyStimulus(8'h00); applyStimulus(8'h00);
    applyStimulus(8'h03); applyStimulus(8'hFF); applyStimulus(8'h01);
    checkOutput("sw_wr", {31'd0, mem_port_wr}, 32'd1);
    checkOutput("sw_addr", {22'd0, mem_port_addr}, 32'd0);
    checkOutput("sw_data", {14'd0, mem_port_data}, 32'h3FF01);
    checkOutput("sw_cpu_rst_held", {31'd0, cpu_rst}, 32'd1);
    sendCsum(8'd0);
    waitDone();
    checkOutput("sw_cpu_rst_off", {31'd0, cpu_rst}, 32'd0);
    checkOutput("sw_busy_off", {31'd0, busy}, 32'd0);
    checkOutput("sw_err", {31'd0, err}, 32'd0);
    idleCycles(1);
    checkOutput("sw_done_pulse", {31'd0, done}, 32'd0);
    checkOutput("sw_data_hold", {14'd0, mem_port_data}, 32'h3FF01);
    checkOutput("sw_wr_count", wr_cnt - base, 32'd1);
    checkOutput("sw_done_count", done_cnt - dbase, 32'd1);

    // Full 1024-word image, word k = k*7.
    base = wr_cnt; dbase = done_cnt;
    sendSync();
    applyStimulus(8'h03); applyStimulus(8'hFF);
    for (int k = 0; k < 1024; k++) begin
      w = 18'(k * 7);
      applyStimulus({6'd0, w[17:16]});
      applyStimulus(w[15:8]);
      applyStimulus(w[7:0]);
    end
    sendCsum(8'd0);
    waitDone();
    idleCycles(2);
    checkOutput("full_wr_count", wr_cnt - base, 32'd1024);
    checkOutput("full_done_count", done_cnt - dbase, 32'd1);
    for (int k = 0; k < 1024; k++) begin
      checkOutput($sformatf("full_addr_%0d", k), {22'd0, wr_addr[base + k]}, 32'(k));
      checkOutput($sformatf("full_data_%0d", k), {14'd0, wr_data[base + k]}, 32'(k * 7));
    end

    // Bad length header, then recovery with a valid frame.
    base = wr_cnt; dbase = done_cnt;
    sendSync();
    applyStimulus(8'h04);
    applyStimulus(8'h00);
    checkOutput("hdr_err", {31'd0, err}, 32'd1);
    checkOutput("hdr_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    checkOutput("hdr_busy", {31'd0, busy}, 32'd0);
    checkOutput("hdr_no_wr", wr_cnt - base, 32'd0);
    sendSync();
    checkOutput("rec_err_clr", {31'd0, err}, 32'd0);
    checkOutput("rec_busy", {31'd0, busy}, 32'd1);
    applyStimulus(8'h00); applyStimulus(8'h00);
    applyStimulus(8'h03); applyStimulus(8'hFF); applyStimulus(8'h01);
    sendCsum(8'd0);
    waitDone();
    checkOutput("rec_err", {31'd0, err}, 32'd0);
    idleCycles(1);

    // Back-to-back words: second B0 arrives during the first write cycle.
    base = wr_cnt; dbase = done_cnt;
    sendSync();
    applyStimulus(8'h00); applyStimulus(8'h01);
    applyStimulus(8'h01); applyStimulus(8'h23); applyStimulus(8'h45);
    checkOutput("b2b_wr_cycle", {31'd0, mem_port_wr}, 32'd1);
    applyStimulus(8'h02); applyStimulus(8'hAB); applyStimulus(8'hCD);
    sendCsum(8'd0);
    waitDone();
    idleCycles(1);
    checkOutput("b2b_wr_count", wr_cnt - base, 32'd2);
    checkOutput("b2b_addr0", {22'd0, wr_addr[base]}, 32'd0);
    checkOutput("b2b_data0", {14'd0, wr_data[base]}, 32'h12345);
    checkOutput("b2b_addr1", {22'd0, wr_addr[base + 1]}, 32'd1);
    checkOutput("b2b_data1", {14'd0, wr_data[base + 1]}, 32'h2ABCD);

    // Timeout after silence inside a frame.
    base = wr_cnt;
    sendSync();
    applyStimulus(8'h00); applyStimulus(8'h01); applyStimulus(8'h00);
    idleCycles(90);
    checkOutput("tmo_not_yet", {31'd0, err}, 32'd0);
    checkOutput("tmo_busy", {31'd0, busy}, 32'd1);
    idleCycles(12);
    checkOutput("tmo_err", {31'd0, err}, 32'd1);
    checkOutput("tmo_busy_off", {31'd0, busy}, 32'd0);
    checkOutput("tmo_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    checkOutput("tmo_no_wr", wr_cnt - base, 32'd0);

    // Asynchronous reset in the middle of a word.
    sendSync();
    applyStimulus(8'h00); applyStimulus(8'h00); applyStimulus(8'h03);
    checkOutput("ar_busy_before", {31'd0, busy}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("ar_busy", {31'd0, busy}, 32'd0);
    checkOutput("ar_cpu_rst", {31'd0, cpu_rst}, 32'd0);
    checkOutput("ar_err_done_wr", {29'd0, err, done, mem_port_wr}, 32'd0);
    checkOutput("ar_addr", {22'd0, mem_port_addr}, 32'd0);
    checkOutput("ar_data", {14'd0, mem_port_data}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    base = wr_cnt;
    idleCycles(1);
    applyStimulus(8'h11); applyStimulus(8'h22);
    idleCycles(2);
    checkOutput("stray_busy", {31'd0, busy}, 32'd0);
    checkOutput("stray_cpu_rst", {31'd0, cpu_rst}, 32'd0);
    checkOutput("stray_no_wr", wr_cnt - base, 32'd0);

`ifdef LOADER_CHECKSUM_EN
    // Wrong checksum: word still written, error raised, CPU held.
    base = wr_cnt; dbase = done_cnt;
    sendSync();
    applyStimulus(8'h00); applyStimulus(8'h00);
    applyStimulus(8'h03); applyStimulus(8'hFF); applyStimulus(8'h01);
    applyStimulus(8'h04);
    idleCycles(1);
    checkOutput("cs_err", {31'd0, err}, 32'd1);
    checkOutput("cs_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    checkOutput("cs_busy", {31'd0, busy}, 32'd0);
    checkOutput("cs_no_done", done_cnt - dbase, 32'd0);
    checkOutput("cs_wr_count", wr_cnt - base, 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
